umult_acc: RTL
==============

# umult_acc

Sequential accumulator stage directly downstream of the 64x64 unsigned multiplier. It takes the multiplier's 128-bit product stream over a valid/ready handshake and sums a fixed number of products into one wide accumulator. It then presents the finished sum on an output handshake and holds it until the consumer takes it. Typical use is dot-product / multiply-accumulate reduction behind the multiplier.

## Interface
- `PW`, 128, product width (matches multiplier output).
- `ACC_W`, 132, accumulator width; must be ≥ PW.
- `N_TERMS`, 16, products summed per result; range 1..255.
- `CNT_W`, 8, width of the term counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  product is valid.
- `in_ready`  out  1  block accepts a product this cycle.
- `product`  in  PW  unsigned product from the multiplier.
- `clear`  in  1  synchronous abort: discard the partial sum.
- `out_valid`  out  1  `acc_out` holds a finished sum.
- `out_ready`  in  1  consumer takes `acc_out`.
- `acc_out`  out  ACC_W  accumulated sum.
- `term_cnt`  out  CNT_W  products accepted into the current sum.
- `overflow`  out  1  sticky: the current sum exceeded ACC_W bits.

## Operation
- Two-state FSM: ACCUM and DRAIN. Reset state is ACCUM.
- **ACCUM**
  - `in_ready`=1 and `out_valid`=0.
  - A product is accepted on any cycle with `in_valid & in_ready`.
  - On accept: `acc <= acc + zero_extend(product)` and `term_cnt <= term_cnt + 1`.
  - On the accept that brings `term_cnt` to `N_TERMS`: go to DRAIN.
- **DRAIN**
  - `in_ready`=0 and `out_valid`=1.
  - `acc_out`, `term_cnt` and `overflow` are held stable.
  - On `out_ready`: acc=0, term_cnt=0, overflow=0, go to ACCUM.
- `acc_out` is the accumulator register itself in both states. Consumers must only sample it while `out_valid` is high.
- Arithmetic is unsigned. The sum is computed at ACC_W+1 bits, and the carry out of bit ACC_W-1 sets `overflow`. Without saturation the sum wraps modulo 2^ACC_W.
- `clear`
  - Works in either state and takes priority over accept and handoff.
  - Next cycle: acc=0, term_cnt=0, overflow=0, state ACCUM.
  - A product presented in the same cycle as `clear` is dropped, even though `in_ready` was high.
- `in_ready` depends only on state, never on `in_valid`. There is no combinational input-to-output path except through registers.

## Timing
- Reset values: `acc_out`=0, `term_cnt`=0, `overflow`=0, `out_valid`=0, `in_ready`=1, state ACCUM.
- Reset is asynchronous and effective immediately, including in the middle of a sum; the partial sum is lost.
- Throughput: one product per cycle in ACCUM.
- Latency: `out_valid` rises on the clock edge that accepts the N_TERMS-th product, so it is visible one cycle after that accept.
- If `out_ready` is already high on entry, DRAIN lasts one cycle, and `in_ready` returns the following cycle. Minimum period is N_TERMS+1 cycles per result.
- `N_TERMS`=1: every accept goes straight to DRAIN.
- `out_ready` while in ACCUM has no effect.

## Configuration
- `UMULT_ACC_SATURATE_EN`
  - Defined: on a carry out, `acc` is set to all ones (2^ACC_W−1) and stays there until handoff or clear. `overflow` is still set.
  - Undefined: the sum wraps modulo 2^ACC_W and `overflow` is set.

## Test plan
- 16 products of 255×255=65025, back to back, `out_ready`=1 → `out_valid` one cycle after the 16th accept, `acc_out`=1040400, `term_cnt`=16, `overflow`=0, `in_ready` high again the cycle after handoff.
- Same stream with `in_valid` gapped every other cycle and `out_ready` held low 5 cycles → `acc_out`=1040400 held stable through DRAIN, `in_ready`=0 throughout, and no extra product accepted.
- `ACC_W`=128, `N_TERMS`=2, two products of 2^127
  - Macro off → `acc_out`=0, `overflow`=1.
  - Macro on → `acc_out`=2^128−1, `overflow`=1.
- Assert `clear` after 7 of 16 products, with `in_valid` high that cycle → next cycle acc=0 and term_cnt=0. The following 16 products of value 3 give `acc_out`=48.
- Pull `rst_n` low asynchronously (between clock edges) midway through a sum → outputs return to reset values immediately. The sum after release starts from 0.
- `N_TERMS`=1, products 10 then 20 with `out_ready`=1 → two results, 10 then 20, each asserting `out_valid` for one cycle.

Source files
------------

// File: rtl/umult_acc.sv
// Accumulates N_TERMS unsigned products from the multiplier into one wide sum and hands it off.
// Optional UMULT_ACC_SATURATE_EN clamps the sum to all ones on carry-out instead of wrapping.
//
// state | meaning
// ACCUM | accepting products, building the sum
// DRAIN | sum finished, held on acc_out until out_ready
module umult_acc #(
  parameter int PW      = 128,
  parameter int ACC_W   = 132,
  parameter int N_TERMS = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    product,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] term_cnt,
  output logic             overflow
);

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] N_TC = CNT_W'(N_TERMS);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_term;
  logic             accept;
  logic             handoff;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DRAIN);
  assign acc_out   = acc;

  // clear wins over both accept and handoff
  assign accept    = in_valid & in_ready & ~clear;
  assign handoff   = out_ready & out_valid & ~clear;
  assign cnt_inc   = term_cnt + 1'b1;
  assign last_term = (cnt_inc == N_TC);

  always_comb begin
    prod_ext = '0;
    prod_ext[PW-1:0] = product;
    sum   = {1'b0, acc} + prod_ext;
    carry = sum[ACC_W];
`ifdef UMULT_ACC_SATURATE_EN
    acc_add = carry ? '1 : sum[ACC_W-1:0];
`else
    acc_add = sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last_term) state_nxt = DRAIN;
        DRAIN:   if (handoff) state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      term_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear || handoff) begin
      acc      <= '0;
      term_cnt <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      acc      <= acc_add;
      term_cnt <= cnt_inc;
      overflow <= overflow | carry;
    end
  end

endmodule
